// File: rtl/ay_psg.sv
// ay_psg: AY-3-8910-compatible programmable sound generator.
//   Three square-wave tone channels, a 17-bit LFSR noise source, a 16-bit-period envelope
//   generator and an R7-controlled mixer. Register writes arrive from the mmap router as
//   one-cycle strobes; reads are combinational from the selected register.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   ay_req     one-cycle write strobe
//   ay_reg     register index R0..R15
//   ay_data_o  write data (CPU -> PSG)
//   ay_data_i  read data (PSG -> CPU), combinational from ay_reg; R14/R15 read as 8'hFF
//   ch_a/b/c   registered 4-bit channel levels
//   mix        registered sum ch_a+ch_b+ch_c (0..45)
//   pwm        1-bit PWM of mix
//
// Configuration:
//   AY_PWM_EN  when defined, pwm is driven from a 6-bit free-running counter compare
//              (duty = mix/64); when undefined, pwm is tied low and the counter is absent.

module ay_psg #(
    parameter int unsigned CLK_DIV = 14
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ay_req,
    input  logic [3:0] ay_reg,
    input  logic [7:0] ay_data_o,
    output logic [7:0] ay_data_i,
    output logic [3:0] ch_a,
    output logic [3:0] ch_b,
    output logic [3:0] ch_c,
    output logic [5:0] mix,
    output logic       pwm
);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [7:0] regs_q [14];

    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
            default:                 reg_mask = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 14; i++) regs_q[i] <= 8'h00;
        end else if (ay_req && (ay_reg < 4'd14)) begin
            regs_q[ay_reg] <= ay_data_o & reg_mask(ay_reg);
        end
    end

    always_comb begin
        ay_data_i = 8'hFF;
        if (ay_reg < 4'd14) ay_data_i = regs_q[ay_reg];
    end

    // ------------------------------------------------------------------
    // Timebase: chip clock prescaler, /8 tone strobe, /2 noise/envelope strobe
    // ------------------------------------------------------------------
    logic [7:0] pre_q;
    logic [2:0] step8_q;
    logic       half_q;
    logic       chip_tick;
    logic       tone_tick;
    logic       slow_tick;

    assign chip_tick = (pre_q == 8'(CLK_DIV - 1));
    assign tone_tick = chip_tick && (step8_q == 3'd7);
    assign slow_tick = tone_tick && half_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q   <= 8'd0;
            step8_q <= 3'd0;
            half_q  <= 1'b0;
        end else begin
            pre_q <= chip_tick ? 8'd0 : pre_q + 8'd1;
            if (chip_tick) step8_q <= step8_q + 3'd1;
            if (tone_tick) half_q  <= ~half_q;
        end
    end

    // ------------------------------------------------------------------
    // Tone generators
    // ------------------------------------------------------------------
    function automatic logic [11:0] tone_period(input logic [7:0] hi, input logic [7:0] lo);
        logic [11:0] p;
        p = {hi[3:0], lo};
        tone_period = (p == 12'd0) ? 12'd1 : p;
    endfunction

    logic [11:0] tone_per [3];
    logic [2:0]  tone;

    always_comb begin
        tone_per[0] = tone_period(regs_q[1], regs_q[0]);
        tone_per[1] = tone_period(regs_q[3], regs_q[2]);
        tone_per[2] = tone_period(regs_q[5], regs_q[4]);
    end

    for (genvar g = 0; g < 3; g++) begin : g_tone
        logic [11:0] cnt_q;
        logic        sq_q;
        logic [12:0] cnt_inc;

        assign cnt_inc = {1'b0, cnt_q} + 13'd1;

        // >= rather than == so a period shrunk below the running count wraps on the next tick
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= 12'd0;
                sq_q  <= 1'b0;
            end else if (tone_tick) begin
                if (cnt_inc >= {1'b0, tone_per[g]}) begin
                    cnt_q <= 12'd0;
                    sq_q  <= ~sq_q;
                end else begin
                    cnt_q <= cnt_inc[11:0];
                end
            end
        end

        assign tone[g] = sq_q;
    end

    // ------------------------------------------------------------------
    // Noise generator
    // ------------------------------------------------------------------
    logic [4:0]  noise_cnt_q;
    logic [16:0] lfsr_q;
    logic [5:0]  noise_inc;
    logic [5:0]  noise_per;

    assign noise_inc = {1'b0, noise_cnt_q} + 6'd1;
    assign noise_per = (regs_q[6][4:0] == 5'd0) ? 6'd1 : {1'b0, regs_q[6][4:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            noise_cnt_q <= 5'd0;
            lfsr_q      <= 17'h1;
        end else if (slow_tick) begin
            if (noise_inc >= noise_per) begin
                noise_cnt_q <= 5'd0;
                lfsr_q      <= {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
            end else begin
                noise_cnt_q <= noise_inc[4:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Envelope generator
    // ------------------------------------------------------------------
    logic [15:0] env_cnt_q;
    logic [3:0]  env_step_q;
    logic        env_par_q;
    logic        env_hold_q;
    logic [3:0]  env_hold_lvl_q;
    logic [16:0] env_inc;
    logic [16:0] env_per;
    logic        env_c, env_att, env_alt, env_hold;
    logic [3:0]  env_live;
    logic [3:0]  env_level;
    logic        env_restart;

    assign env_c    = regs_q[13][3];
    assign env_att  = regs_q[13][2];
    assign env_alt  = regs_q[13][1];
    assign env_hold = regs_q[13][0];

    assign env_inc     = {1'b0, env_cnt_q} + 17'd1;
    assign env_per     = ({regs_q[12], regs_q[11]} == 16'd0) ? 17'd1
                                                             : {1'b0, regs_q[12], regs_q[11]};
    // 15-step is the bitwise complement for a 4-bit step
    assign env_live    = (env_att ? env_step_q : ~env_step_q) ^ {4{env_alt & env_par_q}};
    assign env_level   = env_hold_q ? env_hold_lvl_q : env_live;
    assign env_restart = ay_req && (ay_reg == 4'd13);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            env_cnt_q      <= 16'd0;
            env_step_q     <= 4'd0;
            env_par_q      <= 1'b0;
            env_hold_q     <= 1'b0;
            env_hold_lvl_q <= 4'd0;
        end else if (env_restart) begin
            env_cnt_q      <= 16'd0;
            env_step_q     <= 4'd0;
            env_par_q      <= 1'b0;
            env_hold_q     <= 1'b0;
            env_hold_lvl_q <= 4'd0;
        end else if (slow_tick) begin
            if (env_inc >= env_per) begin
                env_cnt_q <= 16'd0;
                if (!env_hold_q) begin
                    if (env_step_q == 4'd15) begin
                        if (!env_c) begin
                            env_hold_q     <= 1'b1;
                            env_hold_lvl_q <= 4'd0;
                        end else if (env_hold) begin
                            // ALT with HOLD parks on the opposite of the final ramp level
                            env_hold_q     <= 1'b1;
                            env_hold_lvl_q <= env_live ^ {4{env_alt}};
                        end else begin
                            env_step_q <= 4'd0;
                            env_par_q  <= ~env_par_q;
                        end
                    end else begin
                        env_step_q <= env_step_q + 4'd1;
                    end
                end
            end else begin
                env_cnt_q <= env_inc[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Mixer and registered outputs
    // ------------------------------------------------------------------
    function automatic logic [3:0] chan_level(input logic       tone_off,
                                              input logic       noise_off,
                                              input logic       tone_bit,
                                              input logic       noise_bit,
                                              input logic [7:0] vol_reg,
                                              input logic [3:0] env_lvl);
        logic       gate;
        logic [3:0] vol;
        gate       = (tone_bit | tone_off) & (noise_bit | noise_off);
        vol        = vol_reg[4] ? env_lvl : vol_reg[3:0];
        chan_level = gate ? vol : 4'd0;
    endfunction

    logic [3:0] lvl_a, lvl_b, lvl_c;

    assign lvl_a = chan_level(regs_q[7][0], regs_q[7][3], tone[0], lfsr_q[0], regs_q[8],
                              env_level);
    assign lvl_b = chan_level(regs_q[7][1], regs_q[7][4], tone[1], lfsr_q[0], regs_q[9],
                              env_level);
    assign lvl_c = chan_level(regs_q[7][2], regs_q[7][5], tone[2], lfsr_q[0], regs_q[10],
                              env_level);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_a <= 4'd0;
            ch_b <= 4'd0;
            ch_c <= 4'd0;
            mix  <= 6'd0;
        end else begin
            ch_a <= lvl_a;
            ch_b <= lvl_b;
            ch_c <= lvl_c;
            mix  <= 6'(lvl_a) + 6'(lvl_b) + 6'(lvl_c);
        end
    end

`ifdef AY_PWM_EN
    logic [5:0] pwm_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= 6'd0;
            pwm       <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 6'd1;
            pwm       <= (pwm_cnt_q < mix);
        end
    end
`else
    assign pwm = 1'b0;
`endif

endmodule

// File: tb/tb_ay_psg.sv
module tb_ay_psg;

    logic       clock = 1'b0;
    logic       reset;
    logic       ay_req;
    logic [3:0] ay_reg;
    logic [7:0] ay_data_o;
    logic [7:0] ay_data_i;
    logic [3:0] ch_a, ch_b, ch_c;
    logic [5:0] mix;
    logic       pwm;

    always #5 clock = ~clock;

    ay_psg #(.CLK_DIV(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .ay_req    (ay_req),
        .ay_reg    (ay_reg),
        .ay_data_o (ay_data_o),
        .ay_data_i (ay_data_i),
        .ch_a      (ch_a),
        .ch_b      (ch_b),
        .ch_c      (ch_c),
        .mix       (mix),
        .pwm       (pwm)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    // Pops the oldest expected value and compares it with the observation
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed %0d but scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e)
            else begin
                bad++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [7:0] d);
        @(negedge clock);
        ay_req    = 1'b1;
        ay_reg    = r;
        ay_data_o = d;
        @(negedge clock);
        ay_req    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Waits (bounded) for ch_a to change; on timeout cycles == budget
    task automatic wait_change(input int budget, output int cycles, output logic [3:0] val);
        logic [3:0] prev;
        prev   = ch_a;
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while ((ch_a === prev) && (cycles < budget));
        val = ch_a;
    endtask

    int          cyc;
    logic [3:0]  v;
    logic [3:0]  cur;
    logic        bits [120];
    logic [16:0] lfsr;
    int          idx;
    int          len;
    int          hi_cnt;

    initial begin
        reset     = 1'b1;
        ay_req    = 1'b0;
        ay_reg    = 4'd0;
        ay_data_o = 8'd0;
        repeat (2) @(negedge clock);

        // ---------------- T1 reset state ----------------
        for (int r = 0; r < 16; r++) begin
            ay_reg = 4'(r);
            exp_q.push_back((r < 14) ? 32'h00 : 32'hFF);
            #1;
            check("reset_read", 32'(ay_data_i));
        end
        exp_q.push_back(0); check("reset_ch_a", 32'(ch_a));
        exp_q.push_back(0); check("reset_ch_b", 32'(ch_b));
        exp_q.push_back(0); check("reset_ch_c", 32'(ch_c));
        exp_q.push_back(0); check("reset_mix",  32'(mix));
        exp_q.push_back(0); check("reset_pwm",  32'(pwm));
        @(negedge clock);
        reset = 1'b0;

        // ---------------- T2 masking ----------------
        write_reg(4'd1, 8'hFF);
        write_reg(4'd6, 8'hFF);
        write_reg(4'd13, 8'hFF);
        write_reg(4'd14, 8'h12);
        write_reg(4'd0, 8'hAB);
        write_reg(4'd8, 8'hFF);
        ay_reg = 4'd1;  exp_q.push_back(32'h0F); #1; check("mask_r1", 32'(ay_data_i));
        ay_reg = 4'd6;  exp_q.push_back(32'h1F); #1; check("mask_r6", 32'(ay_data_i));
        ay_reg = 4'd13; exp_q.push_back(32'h0F); #1; check("mask_r13", 32'(ay_data_i));
        ay_reg = 4'd14; exp_q.push_back(32'hFF); #1; check("r14_ignored", 32'(ay_data_i));
        ay_reg = 4'd0;  exp_q.push_back(32'hAB); #1; check("r0_full", 32'(ay_data_i));
        ay_reg = 4'd8;  exp_q.push_back(32'h1F); #1; check("mask_r8", 32'(ay_data_i));

        // ---------------- T3 tone, period 1 ----------------
        do_reset();
        write_reg(4'd0, 8'd1);
        write_reg(4'd7, 8'hFE);
        write_reg(4'd8, 8'd15);
        cur = 4'd15;
        wait_change(100, cyc, v);
        exp_q.push_back(32'(cur)); check("tone_first", 32'(v));
        for (int k = 0; k < 4; k++) begin
            cur = (cur == 4'd15) ? 4'd0 : 4'd15;
            wait_change(100, cyc, v);
            exp_q.push_back(16);       check("tone_half_period", 32'(cyc));
            exp_q.push_back(32'(cur)); check("tone_level", 32'(v));
            exp_q.push_back(32'(cur)); check("tone_mix", 32'(mix));
        end

        // ---------------- T4 period 0 and period change ----------------
        write_reg(4'd0, 8'd0);
        cur = (cur == 4'd15) ? 4'd0 : 4'd15;
        wait_change(100, cyc, v);
        exp_q.push_back(32'(cur)); check("p0_sync_level", 32'(v));
        for (int k = 0; k < 2; k++) begin
            cur = (cur == 4'd15) ? 4'd0 : 4'd15;
            wait_change(100, cyc, v);
            exp_q.push_back(16);       check("p0_half_period", 32'(cyc));
            exp_q.push_back(32'(cur)); check("p0_level", 32'(v));
        end
        write_reg(4'd0, 8'd4);
        cur = (cur == 4'd15) ? 4'd0 : 4'd15;
        wait_change(200, cyc, v);
        exp_q.push_back(32'(cur)); check("p4_sync_level", 32'(v));
        for (int k = 0; k < 2; k++) begin
            cur = (cur == 4'd15) ? 4'd0 : 4'd15;
            wait_change(200, cyc, v);
            exp_q.push_back(64);       check("p4_half_period", 32'(cyc));
            exp_q.push_back(32'(cur)); check("p4_level", 32'(v));
        end

        // ---------------- T5 envelope attack + hold ----------------
        do_reset();
        write_reg(4'd7, 8'hFF);
        write_reg(4'd8, 8'h10);
        write_reg(4'd11, 8'd1);
        write_reg(4'd13, 8'h0D);
        @(negedge clock);
        exp_q.push_back(0); check("env_start", 32'(ch_a));
        for (int s = 1; s < 16; s++) begin
            wait_change(100, cyc, v);
            exp_q.push_back(32'(s)); check("env_ramp_level", 32'(v));
            if (s > 1) begin
                exp_q.push_back(32); check("env_step_period", 32'(cyc));
            end
        end
        wait_change(200, cyc, v);
        exp_q.push_back(200); check("env_hold_no_change", 32'(cyc));
        exp_q.push_back(15);  check("env_hold_level", 32'(v));
        write_reg(4'd13, 8'h0D);
        @(negedge clock);
        exp_q.push_back(0); check("env_restart_level", 32'(ch_a));
        wait_change(100, cyc, v);
        exp_q.push_back(1); check("env_restart_step1", 32'(v));

        // ---------------- T6 noise ----------------
        lfsr = 17'h1;
        for (int k = 0; k < 120; k++) begin
            bits[k] = lfsr[0];
            lfsr    = {lfsr[0] ^ lfsr[3], lfsr[16:1]};
        end
        do_reset();
        write_reg(4'd8, 8'd15);
        write_reg(4'd7, 8'hF7);
        @(negedge clock);
        exp_q.push_back(15); check("noise_initial", 32'(ch_a));
        // Expected runs (level, length in clocks) starting at the first LFSR shift
        idx = 1;
        for (int r = 0; r < 5; r++) begin
            len = 1;
            while (bits[idx + len] == bits[idx]) len++;
            exp_q.push_back(bits[idx] ? 32'd15 : 32'd0);
            exp_q.push_back(32'(len * 32));
            idx += len;
        end
        wait_change(700, cyc, v);
        check("noise_level", 32'(v));
        for (int r = 0; r < 4; r++) begin
            wait_change(700, cyc, v);
            check("noise_run_length", 32'(cyc));
            check("noise_level", 32'(v));
        end
        wait_change(700, cyc, v);
        check("noise_run_length", 32'(cyc));

        // ---------------- PWM with mix = 32 ----------------
        do_reset();
        write_reg(4'd7, 8'hFF);
        write_reg(4'd8, 8'd15);
        write_reg(4'd9, 8'd15);
        write_reg(4'd10, 8'd2);
        repeat (3) @(negedge clock);
        exp_q.push_back(32); check("mix_sum", 32'(mix));
        hi_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (pwm === 1'b1) hi_cnt++;
        end
`ifdef AY_PWM_EN
        exp_q.push_back(32);
`else
        exp_q.push_back(0);
`endif
        check("pwm_high_count", 32'(hi_cnt));

        // ---------------- async reset mid-operation ----------------
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(0); check("async_reset_mix", 32'(mix));
        exp_q.push_back(0); check("async_reset_ch_a", 32'(ch_a));
        ay_reg = 4'd8;
        exp_q.push_back(0); #1; check("async_reset_r8", 32'(ay_data_i));
        @(negedge clock);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
